// File: rtl/bram_block_reader_if.sv
// Request, BRAM read-port and output-stream signals of the block reader.
// The master side is the reader itself; the slave side is its environment.
interface bram_block_reader_if #(
  parameter int BLOCK_NUM_INDEX   = 6,
  parameter int BLOCK_DEPTH_INDEX = 9,
  parameter int BLOCK_WIDTH       = 32
);
  localparam int AW = BLOCK_NUM_INDEX + BLOCK_DEPTH_INDEX;

  logic                         req_valid;
  logic                         req_ready;
  logic [BLOCK_NUM_INDEX-1:0]   req_block;
  logic [BLOCK_DEPTH_INDEX-1:0] req_len;
  logic [AW-1:0]                bram_raddr;
  logic [BLOCK_WIDTH-1:0]       bram_data_i;
  logic                         out_valid;
  logic                         out_ready;
  logic [BLOCK_WIDTH-1:0]       out_data;
  logic                         out_last;
  logic                         busy;
  logic                         done;

  modport master (
    input  req_valid, req_block, req_len, bram_data_i, out_ready,
    output req_ready, bram_raddr, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    output req_valid, req_block, req_len, bram_data_i, out_ready,
    input  req_ready, bram_raddr, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/bram_block_reader.sv
// Sweeps one BRAM block on the read port and streams its words out with valid/ready.
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   READ  | loading words from the block into the output register
//   DRAIN | last word loaded, waiting for its handshake
module bram_block_reader #(
  parameter int BLOCK_NUM_INDEX   = 6,
  parameter int BLOCK_DEPTH_INDEX = 9,
  parameter int BLOCK_WIDTH       = 32
) (
  input logic                clk,
  input logic                rst,
  bram_block_reader_if.master bus
);
  localparam logic [BLOCK_DEPTH_INDEX:0]   DEPTH_CNT = {1'b1, {BLOCK_DEPTH_INDEX{1'b0}}};
  localparam logic [BLOCK_DEPTH_INDEX:0]   CNT_ONE   = {{BLOCK_DEPTH_INDEX{1'b0}}, 1'b1};
  localparam logic [BLOCK_DEPTH_INDEX-1:0] IDX_ONE   = {{(BLOCK_DEPTH_INDEX-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                       state, state_nxt;
  logic [BLOCK_NUM_INDEX-1:0]   blk_reg, blk_nxt;
  logic [BLOCK_DEPTH_INDEX-1:0] idx, idx_nxt;
  logic [BLOCK_DEPTH_INDEX:0]   cnt, cnt_nxt;
  logic [BLOCK_WIDTH-1:0]       data_reg, data_nxt;
  logic                         valid_reg, valid_nxt;
  logic                         last_reg, last_nxt;
  logic                         done_reg, done_nxt;
  logic                         load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      blk_reg   <= '0;
      idx       <= '0;
      cnt       <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state     <= state_nxt;
      blk_reg   <= blk_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      data_reg  <= data_nxt;
      valid_reg <= valid_nxt;
      last_reg  <= last_nxt;
      done_reg  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    blk_nxt   = blk_reg;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    data_nxt  = data_reg;
    valid_nxt = valid_reg;
    last_nxt  = last_reg;
    done_nxt  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          blk_nxt   = bus.req_block;
          idx_nxt   = '0;
          // a zero length asks for the whole block
          cnt_nxt   = (bus.req_len == '0) ? DEPTH_CNT : {1'b0, bus.req_len};
          state_nxt = READ;
        end
      end
      READ: begin
        load = !valid_reg || bus.out_ready;
        if (load) begin
          data_nxt  = bus.bram_data_i;
          valid_nxt = 1'b1;
          last_nxt  = (cnt == CNT_ONE);
          idx_nxt   = idx + IDX_ONE;
          cnt_nxt   = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (valid_reg && bus.out_ready) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.bram_raddr = {blk_reg, idx};
  assign bus.out_valid  = valid_reg;
  assign bus.out_data   = data_reg;
  assign bus.out_last   = last_reg;
  assign bus.done       = done_reg;
endmodule

// File: tb/tb_bram_block_reader.sv
// Randomized bench for bram_block_reader: a memory array plus an expected-word queue
// per request, with outputs sampled on the falling edge.
module tb_bram_block_reader;
  localparam int NB    = 6;
  localparam int DB    = 9;
  localparam int W     = 32;
  localparam int AW    = NB + DB;
  localparam int DEPTH = 1 << DB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] mem [0:(1<<AW)-1];
  int tests = 0;
  int fails = 0;

  bram_block_reader_if #(.BLOCK_NUM_INDEX(NB), .BLOCK_DEPTH_INDEX(DB), .BLOCK_WIDTH(W)) bus ();

  bram_block_reader #(.BLOCK_NUM_INDEX(NB), .BLOCK_DEPTH_INDEX(DB), .BLOCK_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.bram_data_i = mem[bus.bram_raddr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is at a falling edge with the DUT idle.
  // mode: 0 ready always, 1 random ready, 2 ready pattern 1,0,0, 3 ready low for 5 cycles.
  task automatic run_req(input int blk, input int len, input int mode, input int abort_after,
                         input bit hold_next, input int nblk, input int nlen);
    logic [W-1:0] q[$];
    int n, cyc, pops;
    bit finished, stalled;
    logic [W-1:0] hold_d;
    logic hold_l;
    n = (len == 0) ? DEPTH : len;
    for (int k = 0; k < n; k++) q.push_back(mem[blk * DEPTH + k]);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_block = blk[NB-1:0];
    bus.req_len   = len[DB-1:0];
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold_next) begin
      bus.req_block = nblk[NB-1:0];
      bus.req_len   = nlen[DB-1:0];
    end else begin
      bus.req_valid = 1'b0;
    end
    chk("first_cycle_valid", bus.out_valid, 0);
    chk("first_cycle_busy", bus.busy, 1);
    cyc = 0; pops = 0; finished = 0; stalled = 0;
    hold_d = '0; hold_l = 1'b0;
    while (cyc < 4 * n + 20) begin
      @(negedge clk);
      cyc++;
      if (q.size() == 0) begin
        chk("done_pulse", bus.done, 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_req_ready", bus.req_ready, 1);
        chk("idle_valid", bus.out_valid, 0);
        finished = 1;
        break;
      end
      chk("done_low", bus.done, 0);
      chk("busy_high", bus.busy, 1);
      chk("req_ready_low", bus.req_ready, 0);
      chk("raddr_block", bus.bram_raddr[AW-1:DB], blk);
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, q[0]);
      chk("out_last", bus.out_last, q.size() == 1);
      if (stalled) begin
        chk("hold_data", bus.out_data, hold_d);
        chk("hold_last", bus.out_last, hold_l);
      end
      case (mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        2: bus.out_ready = ((cyc - 1) % 3 == 0);
        default: bus.out_ready = (cyc > 5);
      endcase
      if (bus.out_ready) begin
        void'(q.pop_front());
        pops++;
        stalled = 0;
      end else begin
        stalled = 1;
        hold_d = bus.out_data;
        hold_l = bus.out_last;
      end
      if (pops == abort_after) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_req_ready", bus.req_ready, 1);
        chk("abort_raddr", bus.bram_raddr, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b0;
        return;
      end
    end
    chk("completed_in_budget", finished, 1);
    if (mode == 0) chk("no_bubble_latency", cyc, n + 1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_block = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    for (int k = 0; k < DEPTH; k++) mem[3 * DEPTH + k] = 32'h300 + k;

    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_raddr", bus.bram_raddr, 0);
    rst = 1'b0;
    @(negedge clk);

    run_req(3, 4, 0, -1, 0, 0, 0);
    run_req(63, 0, 0, -1, 0, 0, 0);
    run_req(5, 8, 2, -1, 0, 0, 0);
    run_req(7, 1, 3, -1, 0, 0, 0);
    run_req(10, 6, 1, -1, 1, 20, 5);
    run_req(20, 5, 0, -1, 0, 0, 0);
    run_req(12, 10, 0, 3, 0, 0, 0);
    run_req(12, 10, 0, -1, 0, 0, 0);
    for (int t = 0; t < 10; t++) begin
      run_req($urandom_range(0, 63), $urandom_range(0, 40), $urandom_range(0, 2), -1, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
